// File: rtl/spi_cipher_cmd_ctrl.sv
// Purpose: SPI command front-end for the block-cipher core: frame decode, key/block shadow
//          staging with exact-length commit, start/done handshake, result FIFO, sticky errors.
// Ports:   rx_valid/rx_data/frame_end from the synchronised SPI byte layer, tx_data back to it;
//          key/block/core_start/core_mode/busy to the core, core_done/core_result from it.
// Latency: tx_data and core_start are registered (one cycle after the byte that causes them).
// Backpressure: none on the SPI side; starts are refused (err_rej) when busy or FIFO has no room.
module spi_cipher_cmd_ctrl #(
    parameter int KEY_BYTES   = 8,
    parameter int BLOCK_BYTES = 4,
    parameter int RES_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     frame_end,
    output logic [7:0]               tx_data,
    output logic [8*KEY_BYTES-1:0]   key,
    output logic [8*BLOCK_BYTES-1:0] block,
    output logic                     core_start,
    output logic                     core_mode,
    input  logic                     core_done,
    input  logic [8*BLOCK_BYTES-1:0] core_result,
    output logic                     busy
);

    localparam int PW = $clog2(RES_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [7:0] CMD_WR_KEY = 8'h01;
    localparam logic [7:0] CMD_WR_BLK = 8'h02;
    localparam logic [7:0] CMD_ENC    = 8'h03;
    localparam logic [7:0] CMD_DEC    = 8'h04;
    localparam logic [7:0] CMD_STATUS = 8'h05;
    localparam logic [7:0] CMD_READ   = 8'h06;
    localparam logic [7:0] CMD_CLEAR  = 8'h07;

    // Frame lengths (command byte included) compared against the 8-bit count.
    localparam logic [8:0]  KEY_LEN = 9'(KEY_BYTES + 1);
    localparam logic [8:0]  BLK_LEN = 9'(BLOCK_BYTES + 1);
    localparam logic [CW:0] DEPTH_X = (CW + 1)'(RES_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);

    // State
    logic [7:0]               byte_cnt_q, byte_cnt_d;
    logic [7:0]               cmd_q, cmd_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic [8*KEY_BYTES-1:0]   key_sh_q, key_sh_d;
    logic [8*KEY_BYTES-1:0]   key_q, key_d;
    logic [8*BLOCK_BYTES-1:0] blk_sh_q, blk_sh_d;
    logic [8*BLOCK_BYTES-1:0] block_q, block_d;
    logic                     start_q, start_d;
    logic                     mode_q, mode_d;
    logic                     busy_q, busy_d;
    logic                     err_cmd_q, err_cmd_d;
    logic                     err_rej_q, err_rej_d;
    logic                     err_len_q, err_len_d;
    logic                     rd_ok_q, rd_ok_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            fifo_cnt_q, fifo_cnt_d;
    logic [8*BLOCK_BYTES-1:0] mem_q [RES_DEPTH];

    // Combinational helpers
    logic                     fifo_empty, fifo_full;
    logic [7:0]               status;
    logic [8*BLOCK_BYTES-1:0] head;
    logic [7:0]               head_sel;
    logic [7:0]               cnt_upd;
    logic [7:0]               data_idx;
    logic                     cmd_byte;
    logic                     start_ok;
    logic                     push, pop, flush;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == DEPTH_C);
    assign status     = {2'b00, err_cmd_q, err_rej_q, err_len_q, fifo_full, fifo_empty, busy_q};
    assign head       = mem_q[rd_ptr_q];
    // A start is only taken when the result it will produce is guaranteed a FIFO slot.
    assign start_ok   = !busy_q && (({1'b0, fifo_cnt_q} + {{CW{1'b0}}, busy_q}) < DEPTH_X);

    // Read-out byte: the command byte (count 0) returns head byte 0, data byte k
    // (count k+1) returns head byte k+1, so the index is simply the current count.
    always_comb begin
        head_sel = 8'h00;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (byte_cnt_q == 8'(i)) begin
                head_sel = head[8*i +: 8];
            end
        end
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        cmd_d      = cmd_q;
        tx_data_d  = tx_data_q;
        key_sh_d   = key_sh_q;
        key_d      = key_q;
        blk_sh_d   = blk_sh_q;
        block_d    = block_q;
        start_d    = 1'b0;
        mode_d     = mode_q;
        busy_d     = busy_q;
        err_cmd_d  = err_cmd_q;
        err_rej_d  = err_rej_q;
        err_len_d  = err_len_q;
        rd_ok_d    = rd_ok_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        cmd_byte = rx_valid && (byte_cnt_q == 8'h00);
        data_idx = byte_cnt_q - 8'h01;
        cnt_upd  = byte_cnt_q;
        if (rx_valid && (byte_cnt_q != 8'hFF)) begin
            cnt_upd = byte_cnt_q + 8'h01;
        end
        byte_cnt_d = cnt_upd;

        if (cmd_byte) begin
            cmd_d     = rx_data;
            tx_data_d = 8'h00;
            rd_ok_d   = 1'b0;
            case (rx_data)
                CMD_WR_KEY, CMD_WR_BLK: ;
                CMD_ENC, CMD_DEC: begin
                    if (start_ok) begin
                        start_d = 1'b1;
                        busy_d  = 1'b1;
                        mode_d  = (rx_data == CMD_DEC);
                    end else begin
                        err_rej_d = 1'b1;
                    end
                end
                CMD_STATUS: tx_data_d = status;
                CMD_READ: begin
                    if (!fifo_empty) begin
                        tx_data_d = head_sel;
                        rd_ok_d   = 1'b1;
                    end else begin
                        err_rej_d = 1'b1;
                    end
                end
                CMD_CLEAR: begin
                    flush     = 1'b1;
                    err_cmd_d = 1'b0;
                    err_rej_d = 1'b0;
                    err_len_d = 1'b0;
                end
                default: err_cmd_d = 1'b1;
            endcase
        end else if (rx_valid) begin
            tx_data_d = 8'h00;
            case (cmd_q)
                CMD_WR_KEY: begin
                    for (int i = 0; i < KEY_BYTES; i++) begin
                        if (data_idx == 8'(i)) key_sh_d[8*i +: 8] = rx_data;
                    end
                end
                CMD_WR_BLK: begin
                    for (int i = 0; i < BLOCK_BYTES; i++) begin
                        if (data_idx == 8'(i)) blk_sh_d[8*i +: 8] = rx_data;
                    end
                end
                CMD_STATUS: tx_data_d = status;
                CMD_READ:   tx_data_d = rd_ok_q ? head_sel : 8'h00;
                default: ;
            endcase
        end

        // End of frame sees the count including any byte arriving in the same cycle;
        // an empty frame (no bytes at all) carries no command and does nothing.
        if (frame_end) begin
            byte_cnt_d = 8'h00;
            if (cnt_upd != 8'h00) begin
                case (cmd_d)
                    CMD_WR_KEY: begin
                        if ({1'b0, cnt_upd} == KEY_LEN) key_d = key_sh_d;
                        else                            err_len_d = 1'b1;
                    end
                    CMD_WR_BLK: begin
                        if ({1'b0, cnt_upd} == BLK_LEN) block_d = blk_sh_d;
                        else                            err_len_d = 1'b1;
                    end
                    CMD_READ: begin
                        if (rd_ok_d && !fifo_empty && ({1'b0, cnt_upd} >= BLK_LEN)) pop = 1'b1;
                    end
                    default: ;
                endcase
            end
            rd_ok_d = 1'b0;
        end

        // Results arriving with nothing in flight are stale (e.g. after reset).
        if (core_done && busy_q) begin
            busy_d = 1'b0;
            push   = 1'b1;
        end

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (flush) begin
            // Discard everything older; a result pushed this cycle sits at the old write
            // pointer, which becomes the new head.
            rd_ptr_d   = wr_ptr_q;
            fifo_cnt_d = push ? CW'(1) : '0;
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            cmd_q      <= '0;
            tx_data_q  <= '0;
            key_sh_q   <= '0;
            key_q      <= '0;
            blk_sh_q   <= '0;
            block_q    <= '0;
            start_q    <= 1'b0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_cmd_q  <= 1'b0;
            err_rej_q  <= 1'b0;
            err_len_q  <= 1'b0;
            rd_ok_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            cmd_q      <= cmd_d;
            tx_data_q  <= tx_data_d;
            key_sh_q   <= key_sh_d;
            key_q      <= key_d;
            blk_sh_q   <= blk_sh_d;
            block_q    <= block_d;
            start_q    <= start_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            err_cmd_q  <= err_cmd_d;
            err_rej_q  <= err_rej_d;
            err_len_q  <= err_len_d;
            rd_ok_q    <= rd_ok_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) mem_q[wr_ptr_q] <= core_result;
        end
    end

    assign tx_data    = tx_data_q;
    assign key        = key_q;
    assign block      = block_q;
    assign core_start = start_q;
    assign core_mode  = mode_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_cipher_cmd_ctrl.sv
// Purpose: directed self-checking bench for spi_cipher_cmd_ctrl with default parameters.
// Latency: inputs driven on the falling edge, outputs sampled on the following falling edge.
// Backpressure: none; the core is modelled by explicit core_done pulses.
module tb_spi_cipher_cmd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        frame_end;
    logic [7:0]  tx_data;
    logic [63:0] key;
    logic [31:0] block;
    logic        core_start;
    logic        core_mode;
    logic        core_done;
    logic [31:0] core_result;
    logic        busy;

    int nvec = 0;
    int nmis = 0;

    logic [7:0] fb[$];
    logic [7:0] txs[$];
    logic       start_after_cmd;
    logic       start_later;

    spi_cipher_cmd_ctrl #(.KEY_BYTES(8), .BLOCK_BYTES(4), .RES_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .frame_end  (frame_end),
        .tx_data    (tx_data),
        .key        (key),
        .block      (block),
        .core_start (core_start),
        .core_mode  (core_mode),
        .core_done  (core_done),
        .core_result(core_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left on a falling edge; the byte is sampled on the rising edge between.
    task automatic send_byte(input logic [7:0] b, output logic [7:0] t, output logic st);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        t  = tx_data;
        st = core_start;
        @(negedge clk);
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_frame();
        logic [7:0] t;
        logic       st;
        txs = {};
        start_after_cmd = 1'b0;
        start_later     = 1'b0;
        foreach (fb[i]) begin
            send_byte(fb[i], t, st);
            txs.push_back(t);
            if (i == 0) start_after_cmd = st;
            if (core_start) start_later = 1'b1;
        end
        end_frame();
    endtask

    task automatic read_status(output logic [7:0] s);
        fb = {8'h05};
        run_frame();
        s = txs[0];
    endtask

    task automatic pulse_done(input logic [31:0] r);
        core_result = r;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] st;

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; frame_end = 1'b0;
        core_done = 1'b0; core_result = '0;
        @(negedge clk);
        @(negedge clk);

        chk("rst_tx",    {56'd0, tx_data}, 64'h0);
        chk("rst_key",   key, 64'h0);
        chk("rst_block", {32'd0, block}, 64'h0);
        chk("rst_ctl",   {61'd0, core_start, core_mode, busy}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        read_status(st); chk("rst_status", {56'd0, st}, 64'h02);

        // Exact-length key write commits.
        fb = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        run_frame();
        chk("key_commit", key, 64'h0706050403020100);
        read_status(st); chk("key_status", {56'd0, st}, 64'h02);

        // Short key write leaves key alone and flags err_len.
        fb = {8'h01, 8'hAA, 8'hBB, 8'hCC};
        run_frame();
        chk("key_short", key, 64'h0706050403020100);
        read_status(st); chk("err_len_status", {56'd0, st}, 64'h0A);

        fb = {8'h07}; run_frame();
        read_status(st); chk("clear_status", {56'd0, st}, 64'h02);

        // Encrypt round trip.
        fb = {8'h02, 8'h77, 8'h68, 8'h65, 8'h65}; run_frame();
        chk("block_commit", {32'd0, block}, 64'h65656877);
        rx_valid = 1'b1; rx_data = 8'h03;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("enc_start", {61'd0, core_start, core_mode, busy}, 64'h5);
        @(negedge clk);
        chk("enc_start_once", {63'd0, core_start}, 64'h0);
        end_frame();
        read_status(st); chk("busy_status", {56'd0, st}, 64'h03);
        pulse_done(32'hC69BE9BB);
        chk("done_busy", {63'd0, busy}, 64'h0);
        read_status(st); chk("done_status", {56'd0, st}, 64'h00);

        fb = {8'h06, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame();
        chk("read_bytes", {24'd0, txs[0], txs[1], txs[2], txs[3], txs[4]}, 64'hBBE99BC600);
        read_status(st); chk("read_popped", {56'd0, st}, 64'h02);

        // Partial read keeps the head.
        fb = {8'h03}; run_frame();
        pulse_done(32'h11223344);
        fb = {8'h06, 8'h00, 8'h00}; run_frame();
        chk("partial_bytes", {40'd0, txs[0], txs[1], txs[2]}, 64'h443322);
        read_status(st); chk("partial_nopop", {56'd0, st}, 64'h00);
        fb = {8'h06, 8'h00, 8'h00, 8'h00, 8'h00}; run_frame();
        chk("full_after_partial", {24'd0, txs[0], txs[1], txs[2], txs[3], txs[4]}, 64'h4433221100);
        read_status(st); chk("full_after_status", {56'd0, st}, 64'h02);

        // Fill the FIFO, then a further start must be refused.
        for (int i = 0; i < 4; i++) begin
            fb = {8'h03}; run_frame();
            pulse_done(32'hA0A0A0A0 + 32'(i));
        end
        read_status(st); chk("fifo_full_status", {56'd0, st}, 64'h04);
        fb = {8'h03}; run_frame();
        chk("full_no_start", {62'd0, start_after_cmd, start_later}, 64'h0);
        read_status(st); chk("full_rej_status", {56'd0, st}, 64'h14);
        fb = {8'h07}; run_frame();
        read_status(st); chk("flush_status", {56'd0, st}, 64'h02);

        // Decrypt while busy is refused and does not disturb core_mode.
        fb = {8'h03}; run_frame();
        chk("enc2_start", {63'd0, start_after_cmd}, 64'h1);
        fb = {8'h04}; run_frame();
        chk("busy_rej_nostart", {62'd0, start_after_cmd, core_mode}, 64'h0);
        read_status(st); chk("busy_rej_status", {56'd0, st}, 64'h13);
        pulse_done(32'h55667788);
        fb = {8'h2A}; run_frame();
        read_status(st); chk("bad_cmd_status", {56'd0, st}, 64'h30);
        fb = {8'h07}; run_frame();

        // Asynchronous reset while a decrypt is in flight.
        fb = {8'h04}; run_frame();
        chk("dec_mode_busy", {62'd0, core_mode, busy}, 64'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", {61'd0, core_start, core_mode, busy}, 64'h0);
        chk("async_rst_key", key, 64'h0);
        chk("async_rst_data", {24'd0, tx_data, block}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_done(32'hDEADBEEF);
        read_status(st); chk("stale_done_status", {56'd0, st}, 64'h02);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
